// File: rtl/core_pkg.sv
// Shared definitions for the execute/memory datapath: ALU classes from the
// main decoder, ALU operation codes and the funct3 values the decoder uses.
package core_pkg;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLT = 3'b101
  } alu_ctrl_e;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

endpackage

// File: rtl/alu_core.sv
// 32-bit combinational ALU with a zero flag for branch resolution.
module alu_core
  import core_pkg::*;
(
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic [2:0]  alu_ctrl_in,
  output logic [31:0] alu_result,
  output logic        zero
);

  // Select the operation; add/sub wrap modulo 2^32, slt compares signed.
  always_comb begin
    alu_result = 32'd0;
    case (alu_ctrl_in)
      ALU_ADD: alu_result = src_a + src_b;
      ALU_SUB: alu_result = src_a - src_b;
      ALU_AND: alu_result = src_a & src_b;
      ALU_OR:  alu_result = src_a | src_b;
      ALU_XOR: alu_result = src_a ^ src_b;
      ALU_SLT: begin
        if ($signed(src_a) < $signed(src_b)) begin
          alu_result = 32'd1;
        end else begin
          alu_result = 32'd0;
        end
      end
      default: alu_result = 32'd0;
    endcase
  end

  assign zero = (alu_result == 32'd0);

endmodule

// File: rtl/alu_ctrl_dec.sv
// ALU-control decoder: maps the main decoder's ALU class plus instruction
// fields onto the 3-bit operation executed by the ALU.
module alu_ctrl_dec
  import core_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       op5,
  input  logic       funct7_5,
  output logic [2:0] alu_control
);

  // Decode ALU class and funct fields; subtract only for R-type with bit 30 set.
  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          F3_ADD_SUB: begin
            if (op5 && funct7_5) begin
              alu_control = ALU_SUB;
            end else begin
              alu_control = ALU_ADD;
            end
          end
          F3_SLT:  alu_control = ALU_SLT;
          F3_XOR:  alu_control = ALU_XOR;
          F3_OR:   alu_control = ALU_OR;
          F3_AND:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/dmem.sv
// Word-addressed data memory: synchronous whole-word write, combinational
// read, asynchronous clear of every word on reset.
module dmem #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_write,
  input  logic [31:0] mem_adr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata
);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] idx;
  logic          unused_adr_bits;

  // Byte offset and bits above the index are dropped, so addresses wrap.
  assign idx             = mem_adr[AW+1:2];
  assign unused_adr_bits = ^{mem_adr[31:AW+2], mem_adr[1:0]};

  // Clear all words on reset; otherwise write only on a definite enable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= 32'd0;
      end
    end else if (mem_write == 1'b1) begin
      mem[idx] <= mem_wdata;
    end
  end

  assign mem_rdata = reset ? 32'd0 : mem[idx];

endmodule

// File: rtl/exec_mem_unit.sv
// Execute/memory datapath: ALU-control decoder, ALU and data memory.
// The three parts share no state; pipeline registers live outside.
module exec_mem_unit
  import core_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  alu_op,
  input  logic [2:0]  funct3,
  input  logic        op5,
  input  logic        funct7_5,
  output logic [2:0]  alu_control,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic [2:0]  alu_ctrl_in,
  output logic [31:0] alu_result,
  output logic        zero,
  input  logic        mem_write,
  input  logic [31:0] mem_adr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata
);

  alu_ctrl_dec u_dec (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .op5         (op5),
    .funct7_5    (funct7_5),
    .alu_control (alu_control)
  );

  alu_core u_alu (
    .src_a       (src_a),
    .src_b       (src_b),
    .alu_ctrl_in (alu_ctrl_in),
    .alu_result  (alu_result),
    .zero        (zero)
  );

  dmem #(.DEPTH(DEPTH), .AW(AW)) u_dmem (
    .clk       (clk),
    .reset     (reset),
    .mem_write (mem_write),
    .mem_adr   (mem_adr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

endmodule

// File: tb/tb_exec_mem_unit.sv
// Self-checking bench for exec_mem_unit: directed cases from the test plan
// plus randomized vectors checked against a behavioural reference model.
module tb_exec_mem_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  alu_op;
  logic [2:0]  funct3;
  logic        op5;
  logic        funct7_5;
  logic [2:0]  alu_control;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [2:0]  alu_ctrl_in;
  logic [31:0] alu_result;
  logic        zero;
  logic        mem_write;
  logic [31:0] mem_adr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int total = 0;
  int bad   = 0;

  logic [31:0] model [64];

  exec_mem_unit #(.DEPTH(64), .AW(6)) dut (
    .clk(clk), .reset(reset), .alu_op(alu_op), .funct3(funct3), .op5(op5),
    .funct7_5(funct7_5), .alu_control(alu_control), .src_a(src_a), .src_b(src_b),
    .alu_ctrl_in(alu_ctrl_in), .alu_result(alu_result), .zero(zero),
    .mem_write(mem_write), .mem_adr(mem_adr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Reference decoder from the opcode table.
  function automatic logic [2:0] dec_ref(input logic [1:0] op, input logic [2:0] f3,
                                         input logic o5, input logic f7);
    if (op == 2'd0) return 3'd0;
    if (op == 2'd1) return 3'd1;
    if (op == 2'd3) return 3'd0;
    if (f3 == 3'd0) return (o5 && f7) ? 3'd1 : 3'd0;
    if (f3 == 3'd2) return 3'd5;
    if (f3 == 3'd4) return 3'd4;
    if (f3 == 3'd6) return 3'd3;
    if (f3 == 3'd7) return 3'd2;
    return 3'd0;
  endfunction

  // Reference ALU using wide arithmetic and a sign-bit based slt.
  function automatic logic [31:0] alu_ref(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint unsigned wa, wb;
    wa = {32'd0, a};
    wb = {32'd0, b};
    case (op)
      3'd0: return 32'((wa + wb) % 64'h1_0000_0000);
      3'd1: return 32'((wa + 64'h1_0000_0000 - wb) % 64'h1_0000_0000);
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: begin
        if (a[31] != b[31]) return a[31] ? 32'd1 : 32'd0;
        return (wa < wb) ? 32'd1 : 32'd0;
      end
      default: return 32'd0;
    endcase
  endfunction

  function automatic int widx(input logic [31:0] adr);
    return int'((adr / 32'd4) % 32'd64);
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 64; i++) model[i] = 32'd0;
  endtask

  task automatic test_reset();
    clear_model();
    for (int i = 0; i < 4; i++) begin
      mem_adr = 32'(i * 52);
      #1;
      total++;
      if (mem_rdata !== 32'd0) begin
        bad++;
        $display("FAIL reset_rdata adr=%h got=%h exp=%h", mem_adr, mem_rdata, 32'd0);
      end
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic check_dec(input string nm, input logic [1:0] op, input logic [2:0] f3,
                           input logic o5, input logic f7, input logic [2:0] exp);
    alu_op = op; funct3 = f3; op5 = o5; funct7_5 = f7;
    #1;
    total++;
    if (alu_control !== exp) begin
      bad++;
      $display("FAIL dec_%s got=%b exp=%b", nm, alu_control, exp);
    end
  endtask

  task automatic test_decoder();
    check_dec("sub", 2'b10, 3'b000, 1'b1, 1'b1, 3'b001);
    check_dec("addi", 2'b10, 3'b000, 1'b0, 1'b1, 3'b000);
    check_dec("slt", 2'b10, 3'b010, 1'b1, 1'b0, 3'b101);
    check_dec("or", 2'b10, 3'b110, 1'b1, 1'b0, 3'b011);
    check_dec("and", 2'b10, 3'b111, 1'b1, 1'b0, 3'b010);
    check_dec("xor", 2'b10, 3'b100, 1'b0, 1'b0, 3'b100);
    check_dec("other", 2'b10, 3'b001, 1'b1, 1'b1, 3'b000);
    check_dec("op00", 2'b00, 3'b010, 1'b1, 1'b1, 3'b000);
    check_dec("op01", 2'b01, 3'b111, 1'b0, 1'b0, 3'b001);
    check_dec("op11", 2'b11, 3'b010, 1'b1, 1'b1, 3'b000);
  endtask

  task automatic check_alu(input string nm, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp, input logic expz);
    alu_ctrl_in = op; src_a = a; src_b = b;
    #1;
    total++;
    if (alu_result !== exp || zero !== expz) begin
      bad++;
      $display("FAIL alu_%s got=%h/%b exp=%h/%b", nm, alu_result, zero, exp, expz);
    end
  endtask

  task automatic test_alu();
    check_alu("add_wrap", 3'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1);
    check_alu("sub_neg", 3'd1, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0);
    check_alu("sub_eq", 3'd1, 32'd3, 32'd3, 32'd0, 1'b1);
    check_alu("slt_min", 3'd5, 32'h8000_0000, 32'd1, 32'd1, 1'b0);
    check_alu("slt_neg1", 3'd5, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b1);
    check_alu("and", 3'd2, 32'd6, 32'd5, 32'd4, 1'b0);
    check_alu("or", 3'd3, 32'd6, 32'd5, 32'd7, 1'b0);
    check_alu("xor", 3'd4, 32'd6, 32'd5, 32'd3, 1'b0);
    check_alu("op6", 3'd6, 32'd6, 32'd5, 32'd0, 1'b1);
    check_alu("op7", 3'd7, 32'hFFFF_FFFF, 32'd5, 32'd0, 1'b1);
  endtask

  task automatic test_random_comb();
    logic [31:0] e;
    for (int i = 0; i < 300; i++) begin
      alu_op = 2'($urandom); funct3 = 3'($urandom);
      op5 = 1'($urandom); funct7_5 = 1'($urandom);
      alu_ctrl_in = 3'($urandom);
      src_a = (i % 4 == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      src_b = (i % 4 == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      #1;
      e = alu_ref(alu_ctrl_in, src_a, src_b);
      total++;
      if (alu_control !== dec_ref(alu_op, funct3, op5, funct7_5)) begin
        bad++;
        $display("FAIL rand_dec op=%b f3=%b got=%b exp=%b", alu_op, funct3, alu_control,
                 dec_ref(alu_op, funct3, op5, funct7_5));
      end
      total++;
      if (alu_result !== e || zero !== (e == 32'd0)) begin
        bad++;
        $display("FAIL rand_alu op=%b a=%h b=%h got=%h/%b exp=%h", alu_ctrl_in, src_a, src_b,
                 alu_result, zero, e);
      end
    end
  endtask

  // Write at a negedge, check old data before the edge and new data after.
  task automatic mem_write_check(input string nm, input logic [31:0] adr, input logic [31:0] d);
    @(negedge clk);
    mem_write = 1'b1; mem_adr = adr; mem_wdata = d;
    #1;
    total++;
    if (mem_rdata !== model[widx(adr)]) begin
      bad++;
      $display("FAIL %s_pre got=%h exp=%h", nm, mem_rdata, model[widx(adr)]);
    end
    @(posedge clk);
    model[widx(adr)] = d;
    #1;
    mem_write = 1'b0;
    total++;
    if (mem_rdata !== d) begin
      bad++;
      $display("FAIL %s_post got=%h exp=%h", nm, mem_rdata, d);
    end
  endtask

  task automatic check_read(input string nm, input logic [31:0] adr);
    mem_adr = adr;
    #1;
    total++;
    if (mem_rdata !== model[widx(adr)]) begin
      bad++;
      $display("FAIL %s adr=%h got=%h exp=%h", nm, adr, mem_rdata, model[widx(adr)]);
    end
  endtask

  task automatic test_memory();
    mem_write_check("wr64", 32'h64, 32'h1234_5678);
    check_read("rd66", 32'h66);
    check_read("rd164", 32'h164);
    mem_write_check("rdw", 32'h64, 32'hCAFE_F00D);
    check_read("rd_other", 32'h60);
    // Unknown enable must not write.
    @(negedge clk);
    mem_write = 1'bx; mem_adr = 32'h20; mem_wdata = 32'h5555_AAAA;
    @(posedge clk);
    #1;
    mem_write = 1'b0;
    check_read("x_enable", 32'h20);
  endtask

  task automatic test_random_mem();
    logic [31:0] adr, d;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      adr = $urandom; d = $urandom;
      mem_write = 1'($urandom); mem_adr = adr; mem_wdata = d;
      @(posedge clk);
      if (mem_write) model[widx(adr)] = d;
      #1;
      mem_write = 1'b0;
      check_read("rand_mem", $urandom);
    end
  endtask

  task automatic test_reset_mid();
    mem_write_check("wr_dead", 32'd8, 32'h0000_DEAD);
    #2;
    reset = 1'b1;
    clear_model();
    #1;
    total++;
    if (mem_rdata !== 32'd0) begin
      bad++;
      $display("FAIL reset_mid got=%h exp=%h", mem_rdata, 32'd0);
    end
    mem_write = 1'b1; mem_wdata = 32'h1111_1111;
    @(posedge clk);
    #1;
    total++;
    if (mem_rdata !== 32'd0) begin
      bad++;
      $display("FAIL wr_in_reset got=%h exp=%h", mem_rdata, 32'd0);
    end
    @(negedge clk);
    reset = 1'b0;
    mem_write = 1'b0;
    check_read("after_reset", 32'd8);
    mem_write_check("first_wr", 32'd8, 32'h2222_2222);
  endtask

  initial begin
    reset = 1'b1; alu_op = 2'd0; funct3 = 3'd0; op5 = 1'b0; funct7_5 = 1'b0;
    src_a = 32'd0; src_b = 32'd0; alu_ctrl_in = 3'd0;
    mem_write = 1'b0; mem_adr = 32'd0; mem_wdata = 32'd0;
    test_reset();
    test_decoder();
    test_alu();
    test_random_comb();
    test_memory();
    test_random_mem();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
